// File: rtl/stack_sequencer_if.sv
// Single data-memory port shared by the stack sequencer (master) and the memory (slave).
interface stack_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_rd, mem_wr, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_rd, mem_wr, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/stack_sequencer.sv
// Shared scheduler for multi-word stack transactions (CALL/RET/INT/RTI) and
// arbiter of the data-memory port against MEM-stage loads, stores, PUSH and POP.
module stack_sequencer #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_call_req,
  input  logic                  i_ret_req,
  input  logic                  i_rti_req,
  input  logic                  i_int_req,
  input  logic [2*DATA_W-1:0]   i_pc_in,
  input  logic [2:0]            i_ccr_in,
  input  logic                  i_pipe_rd,
  input  logic                  i_pipe_wr,
  input  logic                  i_pipe_stack,
  input  logic [ADDR_W-1:0]     i_pipe_addr,
  input  logic [DATA_W-1:0]     i_pipe_wdata,
  stack_sequencer_if.master     mem_if,
  output logic [DATA_W-1:0]     o_pipe_rdata,
  output logic                  o_busy,
  output logic                  o_int_ack,
  output logic                  o_pc_load,
  output logic [2*DATA_W-1:0]   o_pc_out,
  output logic                  o_ccr_load,
  output logic [2:0]            o_ccr_out,
  output logic                  o_seq_done,
  output logic [ADDR_W-1:0]     o_sp_out,
  output logic                  o_stack_err
);
  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_HI, S_PUSH_LO, S_PUSH_CCR, S_POP_CCR, S_POP_LO, S_POP_HI
  } state_t;
  typedef enum logic [1:0] {K_CALL, K_RET, K_INT, K_RTI} kind_t;

  localparam logic [ADDR_W-1:0] SP_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] SP_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state, w_state_nxt;
  kind_t               r_kind, w_kind_nxt;
  logic [ADDR_W-1:0]   r_sp, w_sp_nxt, w_sp_inc;
  logic [DATA_W-1:0]   r_lo;
  logic [2*DATA_W-1:0] r_pc;
  logic [2:0]          r_ccr;
  logic                r_stack_err;
  logic                w_req_any, w_accept, w_push, w_pop, w_lo_en;

  assign w_req_any   = i_int_req | i_rti_req | i_ret_req | i_call_req;
  assign w_sp_inc    = r_sp + SP_ONE;
  assign o_busy      = (r_state != S_IDLE) | w_req_any;
  assign o_sp_out    = r_sp;
  assign o_stack_err = r_stack_err;

  // Next-state, port arbitration and per-state strobes
  always_comb begin
    w_state_nxt      = r_state;
    w_kind_nxt       = r_kind;
    w_accept         = 1'b0;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_lo_en          = 1'b0;
    mem_if.mem_rd    = 1'b0;
    mem_if.mem_wr    = 1'b0;
    mem_if.mem_addr  = SP_ZERO;
    mem_if.mem_wdata = {DATA_W{1'b0}};
    o_pipe_rdata     = {DATA_W{1'b0}};
    o_int_ack        = 1'b0;
    o_pc_load        = 1'b0;
    o_pc_out         = {(2*DATA_W){1'b0}};
    o_ccr_load       = 1'b0;
    o_ccr_out        = 3'b000;
    o_seq_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The pipeline owns the port in IDLE; an accepted sequence starts next cycle.
        if (i_pipe_wr) begin
          mem_if.mem_wr    = 1'b1;
          mem_if.mem_wdata = i_pipe_wdata;
          mem_if.mem_addr  = i_pipe_stack ? r_sp : i_pipe_addr;
          w_push           = i_pipe_stack;
        end else if (i_pipe_rd) begin
          mem_if.mem_rd   = 1'b1;
          o_pipe_rdata    = mem_if.mem_rdata;
          mem_if.mem_addr = i_pipe_stack ? w_sp_inc : i_pipe_addr;
          w_pop           = i_pipe_stack;
        end else begin
          mem_if.mem_addr = SP_ZERO;
        end
        w_accept = w_req_any;
        if (i_int_req) begin
          w_kind_nxt  = K_INT;
          w_state_nxt = S_PUSH_HI;
          o_int_ack   = 1'b1;
        end else if (i_rti_req) begin
          w_kind_nxt  = K_RTI;
          w_state_nxt = S_POP_CCR;
        end else if (i_ret_req) begin
          w_kind_nxt  = K_RET;
          w_state_nxt = S_POP_LO;
        end else if (i_call_req) begin
          w_kind_nxt  = K_CALL;
          w_state_nxt = S_PUSH_HI;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PUSH_HI: begin
        mem_if.mem_wr    = 1'b1;
        mem_if.mem_addr  = r_sp;
        mem_if.mem_wdata = r_pc[2*DATA_W-1:DATA_W];
        w_push           = 1'b1;
        w_state_nxt      = S_PUSH_LO;
      end
      S_PUSH_LO: begin
        mem_if.mem_wr    = 1'b1;
        mem_if.mem_addr  = r_sp;
        mem_if.mem_wdata = r_pc[DATA_W-1:0];
        w_push           = 1'b1;
        if (r_kind == K_INT) begin
          w_state_nxt = S_PUSH_CCR;
        end else begin
          w_state_nxt = S_IDLE;
          o_seq_done  = 1'b1;
        end
      end
      S_PUSH_CCR: begin
        mem_if.mem_wr    = 1'b1;
        mem_if.mem_addr  = r_sp;
        mem_if.mem_wdata = {{(DATA_W-3){1'b0}}, r_ccr};
        w_push           = 1'b1;
        o_seq_done       = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      S_POP_CCR: begin
        mem_if.mem_rd   = 1'b1;
        mem_if.mem_addr = w_sp_inc;
        w_pop           = 1'b1;
        o_ccr_load      = 1'b1;
        o_ccr_out       = mem_if.mem_rdata[2:0];
        w_state_nxt     = S_POP_LO;
      end
      S_POP_LO: begin
        mem_if.mem_rd   = 1'b1;
        mem_if.mem_addr = w_sp_inc;
        w_pop           = 1'b1;
        w_lo_en         = 1'b1;
        w_state_nxt     = S_POP_HI;
      end
      S_POP_HI: begin
        mem_if.mem_rd   = 1'b1;
        mem_if.mem_addr = w_sp_inc;
        w_pop           = 1'b1;
        o_pc_load       = 1'b1;
        o_pc_out        = {mem_if.mem_rdata, r_lo};
        o_seq_done      = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_push) begin
      w_sp_nxt = r_sp - SP_ONE;
    end else if (w_pop) begin
      w_sp_nxt = w_sp_inc;
    end else begin
      w_sp_nxt = r_sp;
    end
  end

  // State, stack pointer, operand latches and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_kind      <= K_CALL;
      r_sp        <= SP_RESET;
      r_lo        <= {DATA_W{1'b0}};
      r_pc        <= {(2*DATA_W){1'b0}};
      r_ccr       <= 3'b000;
      r_stack_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kind  <= w_kind_nxt;
      r_sp    <= w_sp_nxt;
      if (w_lo_en) begin
        r_lo <= mem_if.mem_rdata;
      end
      if (w_accept) begin
        r_pc  <= i_pc_in;
        r_ccr <= i_ccr_in;
      end
      // Under/overflow is flagged but the access still wraps.
      if ((w_push && (r_sp == SP_ZERO)) || (w_pop && (r_sp == SP_RESET))) begin
        r_stack_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed scenarios plus randomized
// operations checked cycle by cycle against a stack/memory reference model.
module tb_stack_sequencer;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam logic [AW-1:0] SP_RST = 12'hFFF;
  localparam int K_CALL = 0, K_RET = 1, K_INT = 2, K_RTI = 3, K_NONE = 4;
  localparam int P_NONE = 0, P_PUSH = 1, P_POP = 2, P_ST = 3, P_LD = 4;

  typedef struct packed {
    logic wr; logic rd; logic [AW-1:0] addr; logic [DW-1:0] wd;
    logic pcl; logic [2*DW-1:0] pc; logic ccrl; logic [2:0] ccr;
    logic done; logic busy; logic ack; logic [DW-1:0] prd;
  } ev_t;
  localparam ev_t EV0 = '0;

  logic clk = 1'b0;
  logic rst;
  logic call_req, ret_req, rti_req, int_req;
  logic [2*DW-1:0] pc_in;
  logic [2:0] ccr_in;
  logic pipe_rd, pipe_wr, pipe_stack;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata, pipe_rdata;
  logic busy, int_ack, pc_load, ccr_load, seq_done, stack_err;
  logic [2*DW-1:0] pc_out;
  logic [2:0] ccr_out;
  logic [AW-1:0] sp_out;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  stack_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_call_req(call_req), .i_ret_req(ret_req), .i_rti_req(rti_req), .i_int_req(int_req),
    .i_pc_in(pc_in), .i_ccr_in(ccr_in),
    .i_pipe_rd(pipe_rd), .i_pipe_wr(pipe_wr), .i_pipe_stack(pipe_stack),
    .i_pipe_addr(pipe_addr), .i_pipe_wdata(pipe_wdata),
    .mem_if(mif),
    .o_pipe_rdata(pipe_rdata), .o_busy(busy), .o_int_ack(int_ack),
    .o_pc_load(pc_load), .o_pc_out(pc_out), .o_ccr_load(ccr_load), .o_ccr_out(ccr_out),
    .o_seq_done(seq_done), .o_sp_out(sp_out), .o_stack_err(stack_err)
  );

  // Data memory: asynchronous read, written on the rising edge.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {4'h0, a} ^ 16'hA5C3;
  endfunction

  logic [DW-1:0] mem [0:4095];
  bit mem_vld [0:4095];
  always @(posedge clk) begin
    if (mif.mem_wr === 1'b1) begin
      mem[mif.mem_addr]     <= mif.mem_wdata;
      mem_vld[mif.mem_addr] <= 1'b1;
    end
  end
  assign mif.mem_rdata = mem_vld[mif.mem_addr] ? mem[mif.mem_addr] : init_val(mif.mem_addr);

  // Reference model: a plain stack over an array, predicting one port event per cycle.
  logic [DW-1:0] m_mem [0:4095];
  logic [AW-1:0] m_sp;
  bit m_err;
  ev_t exp_q[$];

  function automatic logic [AW-1:0] m_push(input logic [DW-1:0] d);
    logic [AW-1:0] a = m_sp;
    if (m_sp == 12'h000) m_err = 1'b1;
    m_mem[a] = d;
    m_sp = m_sp - 12'h001;
    return a;
  endfunction

  function automatic logic [AW-1:0] m_pop();
    if (m_sp == SP_RST) m_err = 1'b1;
    m_sp = m_sp + 12'h001;
    return m_sp;
  endfunction

  function automatic ev_t idle_ev(input int k, input int p, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
    ev_t e = '0;
    e.busy = (k != K_NONE);
    e.ack  = (k == K_INT);
    case (p)
      P_PUSH:  begin e.wr = 1'b1; e.wd = pd; e.addr = m_push(pd); end
      P_POP:   begin e.rd = 1'b1; e.addr = m_pop(); e.prd = m_mem[e.addr]; end
      P_ST:    begin e.wr = 1'b1; e.wd = pd; e.addr = pa; m_mem[pa] = pd; end
      P_LD:    begin e.rd = 1'b1; e.addr = pa; e.prd = m_mem[pa]; end
      default: e.addr = 12'h000;
    endcase
    return e;
  endfunction

  function automatic void build_seq(input int k, input logic [2*DW-1:0] pc, input logic [2:0] cc);
    ev_t e = '0;
    logic [DW-1:0] lo;
    e.busy = 1'b1;
    if (k == K_CALL || k == K_INT) begin
      e.wr = 1'b1;
      e.wd = pc[31:16]; e.addr = m_push(e.wd); exp_q.push_back(e);
      e.wd = pc[15:0];  e.addr = m_push(e.wd); e.done = (k == K_CALL); exp_q.push_back(e);
      if (k == K_INT) begin
        e.wd = {13'b0, cc}; e.addr = m_push(e.wd); e.done = 1'b1; exp_q.push_back(e);
      end
    end else begin
      e.rd = 1'b1;
      if (k == K_RTI) begin
        e.addr = m_pop(); e.ccrl = 1'b1; e.ccr = m_mem[e.addr][2:0]; exp_q.push_back(e);
        e.ccrl = 1'b0; e.ccr = 3'b000;
      end
      e.addr = m_pop(); lo = m_mem[e.addr]; exp_q.push_back(e);
      e.addr = m_pop(); e.pcl = 1'b1; e.pc = {m_mem[e.addr], lo}; e.done = 1'b1; exp_q.push_back(e);
    end
  endfunction

  function automatic ev_t obs();
    ev_t o;
    o.wr = mif.mem_wr; o.rd = mif.mem_rd; o.addr = mif.mem_addr; o.wd = mif.mem_wdata;
    o.pcl = pc_load; o.pc = pc_out; o.ccrl = ccr_load; o.ccr = ccr_out;
    o.done = seq_done; o.busy = busy; o.ack = int_ack; o.prd = pipe_rdata;
    return o;
  endfunction

  task automatic drive(input int k, input int p, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic [2*DW-1:0] pc, input logic [2:0] cc);
    call_req = (k == K_CALL); ret_req = (k == K_RET);
    int_req  = (k == K_INT);  rti_req = (k == K_RTI);
    pipe_wr    = (p == P_PUSH) || (p == P_ST);
    pipe_rd    = (p == P_POP)  || (p == P_LD);
    pipe_stack = (p == P_PUSH) || (p == P_POP);
    pipe_addr = pa; pipe_wdata = pd; pc_in = pc; ccr_in = cc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(K_NONE, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_sp = SP_RST; m_err = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== EV0) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs(), EV0); end
    checks++;
    if (sp_out !== 12'hFFF || stack_err !== 1'b0) begin
      errors++; $display("FAIL reset_sp: sp=%h err=%b expected sp=fff err=0", sp_out, stack_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_call_ret();
    ev_t e;
    logic [2*DW-1:0] cap_pc = '0;
    drive(K_CALL, P_NONE, 12'h000, 16'h0000, 32'h0001_2345, 3'b000);
    e = idle_ev(K_CALL, P_NONE, 12'h000, 16'h0000); exp_q.push_back(e);
    build_seq(K_CALL, 32'h0001_2345, 3'b000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); checks++;
      if (obs() !== e) begin errors++; $display("FAIL call_step: got %h expected %h", obs(), e); end
      @(posedge clk); #1 drive(K_NONE, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    end
    checks++;
    if (sp_out !== 12'hFFD || mem[12'hFFF] !== 16'h0001 || mem[12'hFFE] !== 16'h2345) begin
      errors++; $display("FAIL call_result: sp=%h fff=%h ffe=%h expected ffd 0001 2345", sp_out, mem[12'hFFF], mem[12'hFFE]);
    end
    drive(K_RET, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    e = idle_ev(K_RET, P_NONE, 12'h000, 16'h0000); exp_q.push_back(e);
    build_seq(K_RET, 32'h0, 3'b000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); checks++;
      if (pc_load === 1'b1) cap_pc = pc_out;
      if (obs() !== e) begin errors++; $display("FAIL ret_step: got %h expected %h", obs(), e); end
      @(posedge clk); #1 drive(K_NONE, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    end
    checks++;
    if (cap_pc !== 32'h0001_2345 || sp_out !== 12'hFFF || stack_err !== 1'b0) begin
      errors++; $display("FAIL ret_result: pc=%h sp=%h err=%b expected 00012345 fff 0", cap_pc, sp_out, stack_err);
    end
  endtask

  task automatic test_int_rti();
    ev_t e;
    logic [2*DW-1:0] cap_pc = '0;
    logic [2:0] cap_ccr = 3'b000;
    drive(K_INT, P_ST, 12'h010, 16'hBEEF, 32'h0000_0040, 3'b101);
    e = idle_ev(K_INT, P_ST, 12'h010, 16'hBEEF); exp_q.push_back(e);
    build_seq(K_INT, 32'h0000_0040, 3'b101);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); checks++;
      if (obs() !== e) begin errors++; $display("FAIL int_step: got %h expected %h", obs(), e); end
      @(posedge clk); #1 drive(K_NONE, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    end
    checks++;
    if (mem[12'h010] !== 16'hBEEF || mem[12'hFFF] !== 16'h0000 || mem[12'hFFE] !== 16'h0040 || mem[12'hFFD] !== 16'h0005) begin
      errors++; $display("FAIL int_mem: 010=%h fff=%h ffe=%h ffd=%h expected beef 0000 0040 0005",
                         mem[12'h010], mem[12'hFFF], mem[12'hFFE], mem[12'hFFD]);
    end
    drive(K_RTI, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    e = idle_ev(K_RTI, P_NONE, 12'h000, 16'h0000); exp_q.push_back(e);
    build_seq(K_RTI, 32'h0, 3'b000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); checks++;
      if (pc_load === 1'b1) cap_pc = pc_out;
      if (ccr_load === 1'b1) cap_ccr = ccr_out;
      if (obs() !== e) begin errors++; $display("FAIL rti_step: got %h expected %h", obs(), e); end
      @(posedge clk); #1 drive(K_NONE, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    end
    checks++;
    if (cap_ccr !== 3'd5 || cap_pc !== 32'h0000_0040 || sp_out !== 12'hFFF) begin
      errors++; $display("FAIL rti_result: ccr=%0d pc=%h sp=%h expected 5 00000040 fff", cap_ccr, cap_pc, sp_out);
    end
  endtask

  task automatic test_priority();
    ev_t e;
    int i = 0;
    drive(K_INT, P_NONE, 12'h000, 16'h0000, 32'h1111_2222, 3'b011);
    call_req = 1'b1;
    e = idle_ev(K_INT, P_NONE, 12'h000, 16'h0000); exp_q.push_back(e);
    build_seq(K_INT, 32'h1111_2222, 3'b011);
    e = idle_ev(K_CALL, P_NONE, 12'h000, 16'h0000); exp_q.push_back(e);
    build_seq(K_CALL, 32'h3333_4444, 3'b000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); checks++;
      if (obs() !== e) begin errors++; $display("FAIL prio_step%0d: got %h expected %h", i, obs(), e); end
      @(posedge clk); #1;
      if (i == 0) begin int_req = 1'b0; pc_in = 32'h3333_4444; ccr_in = 3'b000; end
      if (i == 4) call_req = 1'b0;
      i++;
    end
  endtask

  task automatic test_rst_mid();
    ev_t e;
    drive(K_CALL, P_NONE, 12'h000, 16'h0000, 32'hCAFE_1234, 3'b000);
    e = idle_ev(K_CALL, P_NONE, 12'h000, 16'h0000); exp_q.push_back(e);
    build_seq(K_CALL, 32'hCAFE_1234, 3'b000);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      @(negedge clk); checks++;
      if (obs() !== e) begin errors++; $display("FAIL rstmid_step%0d: got %h expected %h", i, obs(), e); end
      @(posedge clk); #1 drive(K_NONE, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    m_sp = SP_RST; m_err = 1'b0;
    @(negedge clk); checks++;
    if (obs() !== EV0 || sp_out !== 12'hFFF || stack_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: got %h sp=%h err=%b expected all 0, sp fff", obs(), sp_out, stack_err);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk); checks++;
      if (mif.mem_wr !== 1'b0) begin errors++; $display("FAIL rstmid_nowrite%0d: mem_wr=%b expected 0", i, mif.mem_wr); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_underflow();
    ev_t e;
    drive(K_NONE, P_POP, 12'h123, 16'h0000, 32'h0, 3'b000);
    e = idle_ev(K_NONE, P_POP, 12'h123, 16'h0000);
    @(negedge clk); checks++;
    if (obs() !== e) begin errors++; $display("FAIL underflow_step: got %h expected %h", obs(), e); end
    checks++;
    if (mif.mem_addr !== 12'h000) begin errors++; $display("FAIL underflow_addr: got %h expected 000", mif.mem_addr); end
    @(posedge clk); #1 drive(K_NONE, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
    checks++;
    if (sp_out !== 12'h000 || stack_err !== 1'b1) begin
      errors++; $display("FAIL underflow_result: sp=%h err=%b expected 000 1", sp_out, stack_err);
    end
  endtask

  task automatic test_random();
    ev_t e;
    int k, p;
    logic [2*DW-1:0] pc;
    logic [2:0] cc;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 4); p = $urandom_range(0, 4);
      pc = $urandom; cc = 3'($urandom); pa = AW'($urandom); pd = DW'($urandom);
      drive(k, p, pa, pd, pc, cc);
      e = idle_ev(k, p, pa, pd); exp_q.push_back(e);
      if (k != K_NONE) build_seq(k, pc, cc);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(negedge clk); checks++;
        if (obs() !== e) begin errors++; $display("FAIL rand_step n=%0d op=%0d/%0d: got %h expected %h", n, k, p, obs(), e); end
        // Pipeline strobes raised while a sequence runs must be ignored.
        @(posedge clk); #1 drive(K_NONE, $urandom_range(0, 4), AW'($urandom), DW'($urandom), $urandom, 3'($urandom));
      end
      checks++;
      if (sp_out !== m_sp || stack_err !== m_err) begin
        errors++; $display("FAIL rand_state n=%0d: sp=%h err=%b expected sp=%h err=%b", n, sp_out, stack_err, m_sp, m_err);
      end
    end
    drive(K_NONE, P_NONE, 12'h000, 16'h0000, 32'h0, 3'b000);
  endtask

  task automatic test_final_reset();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); checks++;
    if (stack_err !== 1'b0 || sp_out !== 12'hFFF || obs() !== EV0) begin
      errors++; $display("FAIL final_reset: err=%b sp=%h out=%h expected 0 fff 0", stack_err, sp_out, obs());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) m_mem[a] = init_val(AW'(a));
    test_reset();
    test_call_ret();
    test_int_rti();
    test_priority();
    test_rst_mid();
    test_underflow();
    test_random();
    test_final_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
